priority_encoder_8_to_3: RTL and testbench

PRIORITY_ENCODER_8_TO_3 -- requirements
Module: priority_encoder_8_to_3

---
 rtl/prio_enc_pkg.sv | 14 +
 rtl/priority_encoder_core.sv | 36 +++
 rtl/priority_encoder_8_to_3.sv | 97 +++++++++
 tb/tb_priority_encoder_8_to_3.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prio_enc_pkg.sv
// Shared widths, limits and index-to-code ordering for the 8-to-3 priority encoder.
package prio_enc_pkg;

  localparam int unsigned IN_W       = 8;
  localparam int unsigned CODE_W     = 3;
  localparam int unsigned ERRCNT_W   = 8;
  localparam int unsigned ERRCNT_MAX = 255;

  // Bit-reversed ordering: index = 4*code[0] + 2*code[1] + code[2].
  function automatic logic [CODE_W-1:0] idx_to_code(input logic [CODE_W-1:0] idx);
    return {idx[0], idx[1], idx[2]};
  endfunction

endpackage

// File: rtl/priority_encoder_core.sv
// Combinational winner select, all-zero and multi-hot detection for one request vector.
module priority_encoder_core
  import prio_enc_pkg::*;
#(
  parameter bit MSB_PRIORITY = 1'b1
) (
  input  logic [IN_W-1:0]   in_data,
  output logic [CODE_W-1:0] code,
  output logic              none,
  output logic              multi
);

  logic [CODE_W-1:0] idx;
  logic [3:0]        cnt;
  logic              found;

  always_comb begin
    idx   = '0;
    cnt   = '0;
    found = 1'b0;
    // Ascending scan: MSB priority keeps the last hit, LSB priority keeps the first.
    for (int i = 0; i < IN_W; i++) begin
      if (in_data[i]) begin
        cnt = cnt + 4'd1;
        if (MSB_PRIORITY || !found) begin
          idx = CODE_W'(i);
        end
        found = 1'b1;
      end
    end
    code  = idx_to_code(idx);
    none  = (in_data == '0);
    multi = (cnt >= 4'd2);
  end

endmodule

// File: rtl/priority_encoder_8_to_3.sv
// Registered 8-to-3 priority encoder with valid/ready handshake on both sides.
// Optional saturating multi-hot counter on err_cnt when PRIO_ENC_ERRCNT_EN is defined.
module priority_encoder_8_to_3
  import prio_enc_pkg::*;
#(
  parameter bit MSB_PRIORITY = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_none,
  output logic              out_multi,
  output logic              out_valid,
  input  logic              out_ready
`ifdef PRIO_ENC_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0] err_cnt
`endif
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e            state_q, state_d;
  logic [CODE_W-1:0] code_q, core_code;
  logic              none_q, core_none;
  logic              multi_q, core_multi;
  logic              in_xfer;

  priority_encoder_core #(
    .MSB_PRIORITY(MSB_PRIORITY)
  ) u_core (
    .in_data(in_data),
    .code   (core_code),
    .none   (core_none),
    .multi  (core_multi)
  );

  assign in_ready = (state_q == StEmpty) || out_ready;
  assign in_xfer  = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    if (in_xfer) begin
      state_d = StFull;
    end else if (out_ready) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
      code_q  <= '0;
      none_q  <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (in_xfer) begin
        code_q  <= core_code;
        none_q  <= core_none;
        multi_q <= core_multi;
      end
    end
  end

  assign out_valid = (state_q == StFull);
  assign out_code  = code_q;
  assign out_none  = none_q;
  assign out_multi = multi_q;

`ifdef PRIO_ENC_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (in_xfer && core_multi && (err_cnt_q != ERRCNT_W'(ERRCNT_MAX))) begin
      err_cnt_d = err_cnt_q + ERRCNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  // Multi-hot status is reported per vector only; no history is kept.
`endif

endmodule

// File: tb/tb_priority_encoder_8_to_3.sv
// Directed bench for priority_encoder_8_to_3, both priority modes side by side.
module tb_priority_encoder_8_to_3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       out_ready;

  logic       ready_m, ready_l;
  logic [2:0] code_m, code_l;
  logic       none_m, none_l, multi_m, multi_l, valid_m, valid_l;
`ifdef PRIO_ENC_ERRCNT_EN
  logic [7:0] err_m, err_l;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  priority_encoder_8_to_3 #(.MSB_PRIORITY(1'b1)) dut_msb (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (ready_m),
    .out_code (code_m),
    .out_none (none_m),
    .out_multi(multi_m),
    .out_valid(valid_m),
    .out_ready(out_ready)
`ifdef PRIO_ENC_ERRCNT_EN
    ,
    .err_cnt  (err_m)
`endif
  );

  priority_encoder_8_to_3 #(.MSB_PRIORITY(1'b0)) dut_lsb (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (ready_l),
    .out_code (code_l),
    .out_none (none_l),
    .out_multi(multi_l),
    .out_valid(valid_l),
    .out_ready(out_ready)
`ifdef PRIO_ENC_ERRCNT_EN
    ,
    .err_cnt  (err_l)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: winner index from log2, code from index digits.
  function automatic int msb_idx(input int v);
    return (v == 0) ? 0 : $clog2(v + 1) - 1;
  endfunction

  function automatic int lsb_idx(input int v);
    return (v == 0) ? 0 : $clog2(v & -v);
  endfunction

  function automatic logic [31:0] code_of(input int i);
    return 32'((i % 2) * 4 + ((i / 2) % 2) * 2 + (i / 4));
  endfunction

  // Model: one held vector plus the saturating multi-hot tally.
  logic m_valid;
  int   m_vec;
  int   m_err;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_vec   <= 0;
      m_err   <= 0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      m_valid <= 1'b1;
      m_vec   <= int'(in_data);
      if ($countones(in_data) >= 2 && m_err < 255) m_err <= m_err + 1;
    end else if (out_ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("cmp_in_ready_msb", 32'(ready_m), 32'(!m_valid || out_ready));
    chk("cmp_in_ready_lsb", 32'(ready_l), 32'(!m_valid || out_ready));
    chk("cmp_out_valid_msb", 32'(valid_m), 32'(m_valid));
    chk("cmp_out_valid_lsb", 32'(valid_l), 32'(m_valid));
    if (m_valid) begin
      chk("cmp_code_msb", 32'(code_m), code_of(msb_idx(m_vec)));
      chk("cmp_code_lsb", 32'(code_l), code_of(lsb_idx(m_vec)));
      chk("cmp_none_msb", 32'(none_m), 32'(m_vec == 0));
      chk("cmp_none_lsb", 32'(none_l), 32'(m_vec == 0));
      chk("cmp_multi_msb", 32'(multi_m), 32'($countones(m_vec) >= 2));
      chk("cmp_multi_lsb", 32'(multi_l), 32'($countones(m_vec) >= 2));
    end
`ifdef PRIO_ENC_ERRCNT_EN
    chk("cmp_err_msb", 32'(err_m), 32'(m_err));
    chk("cmp_err_lsb", 32'(err_l), 32'(m_err));
`endif
  end

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] v);
    in_valid = 1'b1;
    in_data  = v;
    cycle();
  endtask

  logic [7:0] vecs [10] = '{8'h01, 8'h80, 8'h40, 8'hC0, 8'h18, 8'h7E, 8'h00, 8'h03, 8'hFF, 8'h55};

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    #1;
    chk("rst_valid", 32'(valid_m), 32'd0);
    chk("rst_code", 32'(code_m), 32'd0);
    chk("rst_none", 32'(none_m), 32'd0);
    chk("rst_multi", 32'(multi_m), 32'd0);
    chk("rst_ready", 32'(ready_m), 32'd1);
`ifdef PRIO_ENC_ERRCNT_EN
    chk("rst_err", 32'(err_m), 32'd0);
`endif
    #11 rst = 1'b0;

    send(8'h20);
    chk("v20_valid", 32'(valid_m), 32'd1);
    chk("v20_code", 32'(code_m), 32'b101);
    chk("v20_none", 32'(none_m), 32'd0);
    chk("v20_multi", 32'(multi_m), 32'd0);

    send(8'h81);
    chk("v81_code_msb", 32'(code_m), 32'b111);
    chk("v81_multi_msb", 32'(multi_m), 32'd1);
    chk("v81_code_lsb", 32'(code_l), 32'b000);
    chk("v81_multi_lsb", 32'(multi_l), 32'd1);
`ifdef PRIO_ENC_ERRCNT_EN
    chk("v81_err", 32'(err_m), 32'd1);
`endif

    send(8'h00);
    chk("v00_none", 32'(none_m), 32'd1);
    chk("v00_code", 32'(code_m), 32'd0);
    chk("v00_multi", 32'(multi_m), 32'd0);
`ifdef PRIO_ENC_ERRCNT_EN
    chk("v00_err", 32'(err_m), 32'd1);
`endif

    send(8'h04);
    out_ready = 1'b0;
    in_data   = 8'h10;
    repeat (5) begin
      cycle();
      chk("hold_code", 32'(code_m), 32'b010);
      chk("hold_valid", 32'(valid_m), 32'd1);
      chk("hold_ready", 32'(ready_m), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("release_ready", 32'(ready_m), 32'd1);
    cycle();
    chk("b2b_valid", 32'(valid_m), 32'd1);
    chk("b2b_code", 32'(code_m), 32'b001);
    send(8'h02);
    chk("v02_code_msb", 32'(code_m), 32'b100);
    chk("v02_code_lsb", 32'(code_l), 32'b100);
    send(8'h0A);
    chk("v0a_code_msb", 32'(code_m), 32'b110);
    chk("v0a_code_lsb", 32'(code_l), 32'b100);
    in_valid = 1'b0;
    in_data  = 8'hAA;
    cycle();
    chk("drain_valid", 32'(valid_m), 32'd0);

    for (int i = 0; i < 10; i++) begin
      in_valid  = 1'b1;
      in_data   = vecs[i];
      out_ready = (i % 3 != 1);
      cycle();
      in_valid = (i % 4 != 2);
      in_data  = ~vecs[i];
      out_ready = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    repeat (2) cycle();

    in_data   = 8'hFF;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    repeat (260) cycle();
`ifdef PRIO_ENC_ERRCNT_EN
    chk("sat_err_msb", 32'(err_m), 32'd255);
    chk("sat_err_lsb", 32'(err_l), 32'd255);
`endif

    out_ready = 1'b0;
    cycle();
    #1 rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(valid_m), 32'd0);
    chk("midrst_ready", 32'(ready_m), 32'd1);
    chk("midrst_code", 32'(code_m), 32'd0);
`ifdef PRIO_ENC_ERRCNT_EN
    chk("midrst_err", 32'(err_m), 32'd0);
`endif
    #4 rst = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycle();
    chk("post_rst_no_dup", 32'(valid_m), 32'd0);
    send(8'h08);
    chk("post_rst_valid", 32'(valid_m), 32'd1);
    chk("post_rst_code", 32'(code_m), 32'b110);
    in_valid = 1'b0;
    cycle();
    chk("post_rst_drain", 32'(valid_m), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
